// File: rtl/fridge_pkg.sv
// -----------------------------------------------------------------------------
// fridge_pkg
// Shared definitions for the fridge status read path: field tags carried in
// bits 7:5 of each frame byte, the default frame header, frame lengths with
// and without the trailing checksum byte, the reader state type and a helper
// that assembles one frame byte from a settings snapshot.
// Optional feature macro used by the reader: FRIDGE_STATUS_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package fridge_pkg;

  localparam logic [2:0] TAG_FGT = 3'b000;
  localparam logic [2:0] TAG_FRT = 3'b001;
  localparam logic [2:0] TAG_FGC = 3'b010;
  localparam logic [2:0] TAG_FRC = 3'b011;
  localparam logic [2:0] TAG_ICE = 3'b100;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  localparam int FRAME_LEN_BASE = 6;
  localparam int FRAME_LEN_CSUM = 7;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Byte 6 is the XOR of bytes 0..5; it is only reachable when the reader is
  // built with the checksum byte enabled.
  function automatic logic [7:0] frame_byte(
    input logic [2:0] idx,
    input logic [7:0] header,
    input logic [4:0] fgt,
    input logic [4:0] frt,
    input logic [4:0] fgc,
    input logic [4:0] frc,
    input logic       ice
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = header;
      3'd1:    b = {TAG_FGT, fgt};
      3'd2:    b = {TAG_FRT, frt};
      3'd3:    b = {TAG_FGC, fgc};
      3'd4:    b = {TAG_FRC, frc};
      3'd5:    b = {TAG_ICE, 4'b0000, ice};
      3'd6:    b = header ^ {TAG_FGT, fgt} ^ {TAG_FRT, frt} ^ {TAG_FGC, fgc}
                 ^ {TAG_FRC, frc} ^ {TAG_ICE, 4'b0000, ice};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fridge_scan_timer.sv
// -----------------------------------------------------------------------------
// fridge_scan_timer
// Free-running scan counter that asks the reader for a periodic frame.
// Counts 0..SCAN_PERIOD-1 while enabled and raises tick for one cycle on the
// last count (the wrap cycle). Held at 0 while disabled. SCAN_PERIOD = 0
// removes the counter and tick stays low.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   en    in   count enable (reader power)
//   tick  out  one-cycle scan request
// -----------------------------------------------------------------------------
module fridge_scan_timer #(
  parameter int SCAN_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  generate
    if (SCAN_PERIOD == 0) begin : g_no_scan
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, en};
      assign tick = 1'b0;
    end else begin : g_scan
      localparam int CW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
      localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_PERIOD - 1);

      logic [CW-1:0] cnt;

      // Tick is decoded from the count so the reader sees it on the same
      // cycle the counter wraps.
      assign tick = en && (cnt == LAST_CNT);

      // Counter restarts from zero whenever power drops so the first scan
      // after power-up is a full period away.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (!en) begin
          cnt <= '0;
        end else if (cnt == LAST_CNT) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fridge_status_reader.sv
// -----------------------------------------------------------------------------
// fridge_status_reader
// Snapshots the stored fridge/freezer settings and streams them as a fixed
// byte frame over valid/ready. A frame starts on rd_req, on a scan tick or on
// a request that arrived while the previous frame was still streaming.
// Build option: define FRIDGE_STATUS_CHECKSUM_EN to append an XOR checksum
// byte (7-byte frame); otherwise the frame is 6 bytes.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   i          in   power; low aborts any frame and holds the block idle
//   rd_req     in   single-cycle frame request
//   fgt/frt    in   fridge / freezer temperature settings (5 bit)
//   fgc/frc    in   fridge / freezer capacity settings (5 bit)
//   ice        in   ice-maker state
//   out_data   out  frame byte
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts the byte
//   out_last   out  current byte ends the frame
//   busy       out  frame in progress
// -----------------------------------------------------------------------------
module fridge_status_reader
  import fridge_pkg::*;
#(
  parameter int         SCAN_PERIOD = 1000,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i,
  input  logic       rd_req,
  input  logic [4:0] fgt,
  input  logic [4:0] frt,
  input  logic [4:0] fgc,
  input  logic [4:0] frc,
  input  logic       ice,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);

`ifdef FRIDGE_STATUS_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN_CSUM - 1);
`else
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN_BASE - 1);
`endif

  logic       scan_tick;
  state_t     state;
  logic [2:0] idx;
  logic       pending;
  logic [4:0] snap_fgt;
  logic [4:0] snap_frt;
  logic [4:0] snap_fgc;
  logic [4:0] snap_frc;
  logic       snap_ice;

  logic       new_req;
  logic       accept;
  logic [2:0] next_idx;
  logic [7:0] next_byte;

  fridge_scan_timer #(
    .SCAN_PERIOD(SCAN_PERIOD)
  ) u_scan_timer (
    .clk (clk),
    .rst (rst),
    .en  (i),
    .tick(scan_tick)
  );

  // A simultaneous rd_req and scan tick collapse into one request.
  assign new_req   = rd_req | scan_tick;
  assign accept    = out_valid & out_ready;
  assign next_idx  = idx + 3'd1;
  assign next_byte = frame_byte(next_idx, HEADER, snap_fgt, snap_frt,
                                snap_fgc, snap_frc, snap_ice);

  // Frame sequencer. Outputs are registered: the next byte is loaded into
  // out_data on the edge that accepts the current one, so out_data stays
  // put while the downstream stalls. Losing power drops straight to IDLE
  // without ever presenting out_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      snap_fgt  <= '0;
      snap_frt  <= '0;
      snap_fgc  <= '0;
      snap_frc  <= '0;
      snap_ice  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (!i) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (new_req || pending) begin
            snap_fgt  <= fgt;
            snap_frt  <= frt;
            snap_fgc  <= fgc;
            snap_frc  <= frc;
            snap_ice  <= ice;
            idx       <= '0;
            pending   <= 1'b0;
            state     <= SEND;
            out_data  <= HEADER;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          // Pending is one deep; a request on the final accept still
          // lands here and produces the follow-up frame.
          if (new_req) begin
            pending <= 1'b1;
          end
          if (accept) begin
            if (idx == LAST_IDX) begin
              state     <= IDLE;
              idx       <= '0;
              out_data  <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              idx      <= next_idx;
              out_data <= next_byte;
              out_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fridge_status_reader.sv
// -----------------------------------------------------------------------------
// tb_fridge_status_reader
// Self-checking bench for fridge_status_reader (SCAN_PERIOD = 20). Directed
// sequences for the basic frame, backpressure, snapshot, pending, auto-scan
// and abort cases, followed by randomized traffic. Every cycle the outputs
// are compared with a frame-level reference model.
// Honours FRIDGE_STATUS_CHECKSUM_EN to expect the 7-byte frame.
// -----------------------------------------------------------------------------
module tb_fridge_status_reader;

  localparam int SP = 20;
`ifdef FRIDGE_STATUS_CHECKSUM_EN
  localparam int LEN = 7;
`else
  localparam int LEN = 6;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       i;
  logic       rd_req;
  logic [4:0] fgt;
  logic [4:0] frt;
  logic [4:0] fgc;
  logic [4:0] frc;
  logic       ice;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Reference model: the frame in flight as a list of bytes and a position.
  bit         m_busy;
  bit         m_pending;
  int         m_pos;
  int         m_scan;
  logic [7:0] m_frame[$];

  logic [7:0] basic_bytes[7];
  int         off_valid_count;

  always #5 clk = ~clk;

  fridge_status_reader #(
    .SCAN_PERIOD(SP),
    .HEADER     (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i        (i),
    .rd_req   (rd_req),
    .fgt      (fgt),
    .frt      (frt),
    .fgc      (fgc),
    .frc      (frc),
    .ice      (ice),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  // Single comparison point: counts and reports one check.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed %h, required %h at %0t", tag,
               observed, expected, $time);
    end
  endtask

  // Build the byte list for a frame from the live settings.
  task automatic buildFrame();
    int x;
    m_frame.delete();
    m_frame.push_back(8'hA5);
    m_frame.push_back(8'(fgt));
    m_frame.push_back(8'(32 + int'(frt)));
    m_frame.push_back(8'(64 + int'(fgc)));
    m_frame.push_back(8'(96 + int'(frc)));
    m_frame.push_back(8'(128 + int'(ice)));
    if (LEN == 7) begin
      x = 0;
      for (int k = 0; k < 6; k++) x = x ^ int'(m_frame[k]);
      m_frame.push_back(8'(x));
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic modelStep();
    bit tick;
    bit req;
    if (rst) begin
      m_busy    = 0;
      m_pending = 0;
      m_pos     = 0;
      m_scan    = 0;
      m_frame.delete();
      return;
    end
    tick   = i && (m_scan == SP - 1);
    m_scan = i ? (m_scan + 1) % SP : 0;
    req    = rd_req || tick;
    if (!i) begin
      m_busy    = 0;
      m_pending = 0;
    end else if (!m_busy) begin
      if (req || m_pending) begin
        buildFrame();
        m_pos     = 0;
        m_busy    = 1;
        m_pending = 0;
      end
    end else begin
      if (req) m_pending = 1;
      if (out_ready) begin
        if (m_pos == LEN - 1) m_busy = 0;
        else m_pos++;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    logic [7:0] exp_data;
    exp_data = m_busy ? m_frame[m_pos] : 8'h00;
    checkOutput($sformatf("%s.data", tag), out_data, exp_data);
    checkOutput($sformatf("%s.valid", tag), {7'b0, out_valid}, {7'b0, m_busy});
    checkOutput($sformatf("%s.last", tag), {7'b0, out_last},
                {7'b0, (m_busy && m_pos == LEN - 1)});
    checkOutput($sformatf("%s.busy", tag), {7'b0, busy}, {7'b0, m_busy});
  endtask

  // Drive one cycle of control inputs, clock, step the model, then compare
  // away from the active edge.
  task automatic applyStimulus(input string tag, input logic r,
                               input logic pwr, input logic req,
                               input logic rdy);
    rst       = r;
    i         = pwr;
    rd_req    = req;
    out_ready = rdy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    basic_bytes[0] = 8'hA5;
    basic_bytes[1] = 8'h04;
    basic_bytes[2] = 8'h32;
    basic_bytes[3] = 8'h43;
    basic_bytes[4] = 8'h62;
    basic_bytes[5] = 8'h81;
    basic_bytes[6] = 8'h33;
    fgt = 5'd4;
    frt = 5'd18;
    fgc = 5'd3;
    frc = 5'd2;
    ice = 1'b1;
    m_busy    = 0;
    m_pending = 0;
    m_pos     = 0;
    m_scan    = 0;

    // Reset
    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus("reset", 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("reset.data0", out_data, 8'h00);
    checkOutput("reset.valid0", {7'b0, out_valid}, 8'h00);

    // Basic frame with out_ready held high
    applyStimulus("basic", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("basic", 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("basic.b0", out_data, basic_bytes[0]);
    for (int k = 1; k < LEN; k++) begin
      applyStimulus("basic", 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("basic.b%0d", k), out_data, basic_bytes[k]);
      checkOutput($sformatf("basic.last%0d", k), {7'b0, out_last},
                  {7'b0, (k == LEN - 1)});
    end
    applyStimulus("basic.end", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("basic.idle", {7'b0, out_valid}, 8'h00);

    // Backpressure on byte 2
    applyStimulus("bp", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("bp", 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("bp", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("bp", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus("bp.stall", 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("bp.hold", out_data, 8'h32);
      checkOutput("bp.holdvalid", {7'b0, out_valid}, 8'h01);
    end
    for (int k = 3; k < LEN; k++) begin
      applyStimulus("bp.resume", 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("bp.b%0d", k), out_data, basic_bytes[k]);
    end
    applyStimulus("bp.end", 1'b0, 1'b1, 1'b0, 1'b1);

    // Snapshot: fgt changes mid-frame, only the next frame sees it
    applyStimulus("snap", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("snap", 1'b0, 1'b1, 1'b1, 1'b1);
    fgt = 5'd9;
    applyStimulus("snap", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("snap.old", out_data, 8'h04);
    for (int k = 2; k < LEN; k++) applyStimulus("snap", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("snap", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("snap", 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("snap", 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("snap.new", out_data, 8'h09);

    // Pending: two requests during this frame merge into one more frame
    applyStimulus("pend", 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("pend", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2 * LEN + 4; k++)
      applyStimulus("pend", 1'b0, 1'b1, 1'b0, 1'b1);

    // Auto-scan with no rd_req, then power off
    applyStimulus("scan", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 70; k++) applyStimulus("scan", 1'b0, 1'b1, 1'b0, 1'b1);
    off_valid_count = 0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus("off", 1'b0, 1'b0, 1'b0, 1'b1);
      if (out_valid) off_valid_count++;
    end
    checkOutput("off.frames", 8'(off_valid_count), 8'h00);

    // Abort on power loss during byte 3, then reset mid-frame
    applyStimulus("abort", 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus("abort", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("abort.off", 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("abort.valid", {7'b0, out_valid}, 8'h00);
    checkOutput("abort.busy", {7'b0, busy}, 8'h00);
    checkOutput("abort.last", {7'b0, out_last}, 8'h00);
    applyStimulus("rstmid", 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("rstmid", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("rstmid", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("rstmid.rst", 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rstmid.data", out_data, 8'h00);
    checkOutput("rstmid.busy", {7'b0, busy}, 8'h00);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      fgt = 5'($urandom);
      frt = 5'($urandom);
      fgc = 5'($urandom);
      frc = 5'($urandom);
      ice = 1'($urandom);
      applyStimulus("rand", 1'($urandom_range(0, 199) == 0),
                    1'($urandom_range(0, 39) != 0),
                    1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count,
             mismatch_count);
    $finish;
  end

endmodule
